// File: rtl/passthrough_entry_ctrl.sv
// MSP passthrough entry controller: parses "$M<" frames for command 0xF5 and
// sequences DShot inhibit, guard time, bridge enable, idle timeout and drain.
module passthrough_entry_ctrl #(
  parameter int unsigned CLK_FREQ_HZ     = 72_000_000,
  parameter int unsigned GUARD_US        = 100,
  parameter int unsigned IDLE_TIMEOUT_MS = 2000,
  parameter int unsigned BYTE_GAP_US     = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       bridge_active,
  input  logic       exit_req,
  output logic       dshot_inhibit,
  output logic       passthrough_enable,
  output logic [1:0] motor_sel,
  output logic       cmd_ack,
  output logic       cmd_nack
);

  localparam int unsigned GUARD_CYC = GUARD_US * (CLK_FREQ_HZ / 1_000_000);
  localparam int unsigned IDLE_CYC  = IDLE_TIMEOUT_MS * (CLK_FREQ_HZ / 1000);
  localparam int unsigned GAP_CYC   = BYTE_GAP_US * (CLK_FREQ_HZ / 1_000_000);
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int BW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_CYC - 1);
  localparam logic [BW-1:0] GAP_LAST   = BW'(GAP_CYC - 1);

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_M    = 3'd1;
  localparam logic [2:0] P_DIR  = 3'd2;
  localparam logic [2:0] P_LEN  = 3'd3;
  localparam logic [2:0] P_CMD  = 3'd4;
  localparam logic [2:0] P_PAY  = 3'd5;
  localparam logic [2:0] P_CSUM = 3'd6;

  localparam logic [1:0] C_OFF   = 2'd0;
  localparam logic [1:0] C_GUARD = 2'd1;
  localparam logic [1:0] C_ON    = 2'd2;

  logic [2:0]    p_state;
  logic [4:0]    len;
  logic [7:0]    cmd;
  logic [7:0]    csum;
  logic [4:0]    pay_cnt;
  logic [7:0]    motor_idx;
  logic [BW-1:0] gap_cnt;

  logic [1:0]    c_state;
  logic          drain;
  logic [GW-1:0] g_cnt;
  logic [IW-1:0] i_cnt;

  logic csum_hit;
  logic frame_ok;
  logic frame_nack;

  // Frame completes on the checksum byte; the control FSM reacts on the same edge.
  assign csum_hit   = rx_valid && (p_state == P_CSUM) && (rx_data == csum) && (cmd == 8'hF5);
  assign frame_ok   = csum_hit && (motor_idx <= 8'd3);
  assign frame_nack = csum_hit && (motor_idx > 8'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state   <= P_IDLE;
      len       <= '0;
      cmd       <= '0;
      csum      <= '0;
      pay_cnt   <= '0;
      motor_idx <= '0;
      gap_cnt   <= '0;
    end else if (rx_valid) begin
      gap_cnt <= '0;
      case (p_state)
        P_IDLE: if (rx_data == 8'h24) p_state <= P_M;
        P_M: begin
          if (rx_data == 8'h4D)      p_state <= P_DIR;
          else if (rx_data == 8'h24) p_state <= P_M;
          else                       p_state <= P_IDLE;
        end
        P_DIR: begin
          if (rx_data == 8'h3C)      p_state <= P_LEN;
          else if (rx_data == 8'h24) p_state <= P_M;
          else                       p_state <= P_IDLE;
        end
        P_LEN: begin
          if (rx_data > 8'd16) begin
            p_state <= P_IDLE;
          end else begin
            len       <= rx_data[4:0];
            csum      <= rx_data;
            motor_idx <= '0;
            p_state   <= P_CMD;
          end
        end
        P_CMD: begin
          cmd     <= rx_data;
          csum    <= csum ^ rx_data;
          pay_cnt <= '0;
          p_state <= (len == 5'd0) ? P_CSUM : P_PAY;
        end
        P_PAY: begin
          csum <= csum ^ rx_data;
          if (pay_cnt == 5'd0) motor_idx <= rx_data;
          if (pay_cnt == len - 5'd1) p_state <= P_CSUM;
          else                       pay_cnt <= pay_cnt + 5'd1;
        end
        P_CSUM:  p_state <= P_IDLE;
        default: p_state <= P_IDLE;
      endcase
    end else if (p_state != P_IDLE) begin
      // A stalled partial frame is dropped so a later frame can resync.
      if (gap_cnt == GAP_LAST) begin
        p_state <= P_IDLE;
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + BW'(1);
      end
    end else begin
      gap_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_state            <= C_OFF;
      drain              <= 1'b0;
      g_cnt              <= '0;
      i_cnt              <= '0;
      dshot_inhibit      <= 1'b0;
      passthrough_enable <= 1'b0;
      motor_sel          <= 2'd0;
      cmd_ack            <= 1'b0;
      cmd_nack           <= 1'b0;
    end else begin
      cmd_ack  <= 1'b0;
      cmd_nack <= frame_nack;
      case (c_state)
        C_OFF: begin
          // Drain keeps DShot inhibited for one guard time after the bridge drops.
          if (drain) begin
            if (g_cnt == GUARD_LAST) begin
              drain         <= 1'b0;
              dshot_inhibit <= 1'b0;
              g_cnt         <= '0;
            end else begin
              g_cnt <= g_cnt + GW'(1);
            end
          end else if (frame_ok) begin
            motor_sel     <= motor_idx[1:0];
            cmd_ack       <= 1'b1;
            dshot_inhibit <= 1'b1;
            g_cnt         <= '0;
            c_state       <= C_GUARD;
          end
        end
        C_GUARD: begin
          if (exit_req) begin
            c_state            <= C_OFF;
            passthrough_enable <= 1'b0;
            drain              <= 1'b1;
            g_cnt              <= '0;
            i_cnt              <= '0;
          end else begin
            if (frame_ok) cmd_ack <= 1'b1;
            if (g_cnt == GUARD_LAST) begin
              c_state            <= C_ON;
              passthrough_enable <= 1'b1;
              g_cnt              <= '0;
              i_cnt              <= '0;
            end else begin
              g_cnt <= g_cnt + GW'(1);
            end
          end
        end
        C_ON: begin
          if (exit_req) begin
            c_state            <= C_OFF;
            passthrough_enable <= 1'b0;
            drain              <= 1'b1;
            g_cnt              <= '0;
            i_cnt              <= '0;
          end else begin
            if (frame_ok) cmd_ack <= 1'b1;
            if (bridge_active || rx_valid) begin
              i_cnt <= '0;
            end else if (i_cnt == IDLE_LAST) begin
              c_state            <= C_OFF;
              passthrough_enable <= 1'b0;
              drain              <= 1'b1;
              g_cnt              <= '0;
              i_cnt              <= '0;
            end else begin
              i_cnt <= i_cnt + IW'(1);
            end
          end
        end
        default: c_state <= C_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_passthrough_entry_ctrl.sv
// Bench for passthrough_entry_ctrl with scaled timing (1 cycle per us).
module tb_passthrough_entry_ctrl;

  localparam int G   = 20;    // guard cycles
  localparam int I   = 1000;  // idle timeout cycles
  localparam int GAP = 100;   // byte gap cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       bridge_active;
  logic       exit_req;
  logic       dshot_inhibit;
  logic       passthrough_enable;
  logic [1:0] motor_sel;
  logic       cmd_ack;
  logic       cmd_nack;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] tx_q[$];

  passthrough_entry_ctrl #(
    .CLK_FREQ_HZ(1_000_000), .GUARD_US(G), .IDLE_TIMEOUT_MS(1), .BYTE_GAP_US(GAP)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .bridge_active(bridge_active), .exit_req(exit_req),
    .dshot_inhibit(dshot_inhibit), .passthrough_enable(passthrough_enable),
    .motor_sel(motor_sel), .cmd_ack(cmd_ack), .cmd_nack(cmd_nack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Ends on the negedge right after the last byte was sampled.
  task automatic send_q(input int gap);
    for (int i = 0; i < tx_q.size(); i++)
      send_byte(tx_q[i], (i == tx_q.size() - 1) ? 0 : gap);
  endtask

  task automatic build_frame(input int len, input logic [7:0] cmd, input logic [7:0] idx,
                             input bit good);
    logic [7:0] x;
    logic [7:0] b;
    tx_q.delete();
    tx_q.push_back(8'h24); tx_q.push_back(8'h4D); tx_q.push_back(8'h3C);
    tx_q.push_back(8'(len)); tx_q.push_back(cmd);
    x = 8'(len) ^ cmd;
    for (int i = 0; i < len; i++) begin
      b = (i == 0) ? idx : 8'($urandom_range(0, 255));
      tx_q.push_back(b);
      x = x ^ b;
    end
    if (!good) x = x ^ 8'($urandom_range(1, 255));
    tx_q.push_back(x);
  endtask

  // Whole-frame reference: 0 = ignored, 1 = accepted (m = motor), 2 = bad motor index.
  function automatic int model_frame(output logic [1:0] m);
    int len;
    logic [7:0] x;
    logic [7:0] v;
    m = 2'd0;
    if (tx_q.size() < 6) return 0;
    if (tx_q[0] != 8'h24 || tx_q[1] != 8'h4D || tx_q[2] != 8'h3C) return 0;
    len = int'(tx_q[3]);
    if (len > 16 || tx_q.size() != 6 + len) return 0;
    x = tx_q[3] ^ tx_q[4];
    for (int i = 0; i < len; i++) x = x ^ tx_q[5 + i];
    if (tx_q[4] != 8'hF5 || x != tx_q[5 + len]) return 0;
    v = (len == 0) ? 8'd0 : tx_q[5];
    if (v > 8'd3) return 2;
    m = v[1:0];
    return 1;
  endfunction

  task automatic pulse_exit();
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; bridge_active = 1'b0; exit_req = 1'b0;
    #1;
    n_checks++;
    if ({dshot_inhibit, passthrough_enable, motor_sel, cmd_ack, cmd_nack} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b exp 000000",
               {dshot_inhibit, passthrough_enable, motor_sel, cmd_ack, cmd_nack});
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reject();
    logic [7:0] frames [3][7];
    frames[0] = '{8'h24, 8'h4D, 8'h3C, 8'h01, 8'hF5, 8'h02, 8'hF7};
    frames[1] = '{8'h24, 8'h4D, 8'h3C, 8'h01, 8'h64, 8'h02, 8'hF6};
    frames[2] = '{8'h24, 8'h4D, 8'h3C, 8'h11, 8'hF5, 8'h02, 8'hF6};
    for (int f = 0; f < 3; f++) begin
      tx_q.delete();
      for (int i = 0; i < 7; i++) tx_q.push_back(frames[f][i]);
      send_q(0);
      n_checks++;
      if (cmd_ack !== 1'b0) begin
        n_errors++; $display("FAIL reject_ack[%0d]: got %b exp 0", f, cmd_ack);
      end
      repeat (3) tick();
      n_checks++;
      if ({dshot_inhibit, passthrough_enable, motor_sel, cmd_ack, cmd_nack} !== 6'b0) begin
        n_errors++;
        $display("FAIL reject_outputs[%0d]: got %b exp 000000", f,
                 {dshot_inhibit, passthrough_enable, motor_sel, cmd_ack, cmd_nack});
      end
    end
  endtask

  task automatic test_nack();
    tx_q = '{8'h24, 8'h4D, 8'h3C, 8'h01, 8'hF5, 8'h05, 8'hF1};
    send_q(0);
    n_checks++;
    if (cmd_nack !== 1'b1 || cmd_ack !== 1'b0) begin
      n_errors++; $display("FAIL nack_pulse: got nack=%b ack=%b exp nack=1 ack=0", cmd_nack, cmd_ack);
    end
    tick();
    n_checks++;
    if (cmd_nack !== 1'b0 || dshot_inhibit !== 1'b0) begin
      n_errors++; $display("FAIL nack_after: got nack=%b inhibit=%b exp 0 0", cmd_nack, dshot_inhibit);
    end
  endtask

  task automatic test_entry();
    tx_q = '{8'h24, 8'h4D, 8'h3C, 8'h01, 8'hF5, 8'h02, 8'hF6};
    send_q(0);
    n_checks++;
    if (cmd_ack !== 1'b1 || motor_sel !== 2'd2 || dshot_inhibit !== 1'b1 || passthrough_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL entry_accept: got ack=%b sel=%0d inh=%b en=%b exp 1 2 1 0",
               cmd_ack, motor_sel, dshot_inhibit, passthrough_enable);
    end
    repeat (G - 1) tick();
    n_checks++;
    if (passthrough_enable !== 1'b0 || cmd_ack !== 1'b0) begin
      n_errors++; $display("FAIL entry_guard_early: got en=%b ack=%b exp 0 0", passthrough_enable, cmd_ack);
    end
    tick();
    n_checks++;
    if (passthrough_enable !== 1'b1 || dshot_inhibit !== 1'b1) begin
      n_errors++; $display("FAIL entry_guard_end: got en=%b inh=%b exp 1 1", passthrough_enable, dshot_inhibit);
    end
    pulse_exit();
    n_checks++;
    if (passthrough_enable !== 1'b0 || dshot_inhibit !== 1'b1) begin
      n_errors++; $display("FAIL entry_exit: got en=%b inh=%b exp 0 1", passthrough_enable, dshot_inhibit);
    end
    repeat (G) tick();
  endtask

  task automatic test_exit_drain();
    build_frame(1, 8'hF5, 8'd1, 1'b1);
    send_q(0);
    repeat (5) tick();
    pulse_exit();
    // Frame during drain must be ignored and must not extend the drain.
    build_frame(1, 8'hF5, 8'd3, 1'b1);
    send_q(0);
    n_checks++;
    if (cmd_ack !== 1'b0 || dshot_inhibit !== 1'b1) begin
      n_errors++; $display("FAIL drain_frame: got ack=%b inh=%b exp 0 1", cmd_ack, dshot_inhibit);
    end
    repeat (G - 1 - 7) tick();
    n_checks++;
    if (dshot_inhibit !== 1'b1) begin
      n_errors++; $display("FAIL drain_hold: got inh=%b exp 1", dshot_inhibit);
    end
    tick();
    n_checks++;
    if (dshot_inhibit !== 1'b0 || motor_sel !== 2'd1) begin
      n_errors++; $display("FAIL drain_end: got inh=%b sel=%0d exp 0 1", dshot_inhibit, motor_sel);
    end
    pulse_exit();
    tick();
    n_checks++;
    if ({dshot_inhibit, passthrough_enable, cmd_ack} !== 3'b0) begin
      n_errors++; $display("FAIL exit_in_off: got %b exp 000", {dshot_inhibit, passthrough_enable, cmd_ack});
    end
  endtask

  task automatic test_random_frames();
    int len; int expv; logic [7:0] cmd; logic [7:0] idx; bit good; logic [1:0] m; logic [1:0] m2;
    for (int n = 0; n < 24; n++) begin
      len  = $urandom_range(0, 3);
      cmd  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hF5;
      idx  = 8'($urandom_range(0, 5));
      good = ($urandom_range(0, 3) != 0);
      build_frame(len, cmd, idx, good);
      expv = model_frame(m);
      send_q(0);
      n_checks++;
      if (cmd_ack !== (expv == 1) || cmd_nack !== (expv == 2)) begin
        n_errors++;
        $display("FAIL rand_resp[%0d]: got ack=%b nack=%b exp ack=%b nack=%b",
                 n, cmd_ack, cmd_nack, expv == 1, expv == 2);
      end
      if (expv == 1) begin
        n_checks++;
        if (motor_sel !== m || dshot_inhibit !== 1'b1) begin
          n_errors++; $display("FAIL rand_sel[%0d]: got sel=%0d inh=%b exp %0d 1", n, motor_sel, dshot_inhibit, m);
        end
        m2 = m + 2'd1;
        build_frame(1, 8'hF5, {6'd0, m2}, 1'b1);
        send_q(0);
        n_checks++;
        if (cmd_ack !== 1'b1 || motor_sel !== m) begin
          n_errors++; $display("FAIL rand_reack[%0d]: got ack=%b sel=%0d exp 1 %0d", n, cmd_ack, motor_sel, m);
        end
        pulse_exit();
        repeat (G + 1) tick();
      end else begin
        repeat (3) tick();
        n_checks++;
        if (dshot_inhibit !== 1'b0) begin
          n_errors++; $display("FAIL rand_idle[%0d]: got inh=%b exp 0", n, dshot_inhibit);
        end
      end
    end
  endtask

  task automatic test_idle_timeout();
    build_frame(1, 8'hF5, 8'd0, 1'b1);
    send_q(0);
    repeat (G) tick();
    for (int p = 0; p < 4; p++) begin
      repeat (I / 2 - 1) tick();
      bridge_active = 1'b1;
      tick();
      bridge_active = 1'b0;
      n_checks++;
      if (passthrough_enable !== 1'b1) begin
        n_errors++; $display("FAIL idle_active[%0d]: got en=%b exp 1", p, passthrough_enable);
      end
    end
    repeat (I - 1) tick();
    n_checks++;
    if (passthrough_enable !== 1'b1) begin
      n_errors++; $display("FAIL idle_early: got en=%b exp 1", passthrough_enable);
    end
    tick();
    n_checks++;
    if (passthrough_enable !== 1'b0 || dshot_inhibit !== 1'b1) begin
      n_errors++; $display("FAIL idle_timeout: got en=%b inh=%b exp 0 1", passthrough_enable, dshot_inhibit);
    end
    repeat (G - 1) tick();
    n_checks++;
    if (dshot_inhibit !== 1'b1) begin
      n_errors++; $display("FAIL idle_drain_hold: got inh=%b exp 1", dshot_inhibit);
    end
    tick();
    n_checks++;
    if (dshot_inhibit !== 1'b0) begin
      n_errors++; $display("FAIL idle_drain_end: got inh=%b exp 0", dshot_inhibit);
    end
  endtask

  task automatic test_byte_gap();
    build_frame(1, 8'hF5, 8'd2, 1'b1);
    send_q(2 * GAP);
    n_checks++;
    if (cmd_ack !== 1'b0 || dshot_inhibit !== 1'b0) begin
      n_errors++; $display("FAIL gap_slow: got ack=%b inh=%b exp 0 0", cmd_ack, dshot_inhibit);
    end
    send_q(0);
    n_checks++;
    if (cmd_ack !== 1'b1 || motor_sel !== 2'd2) begin
      n_errors++; $display("FAIL gap_fast: got ack=%b sel=%0d exp 1 2", cmd_ack, motor_sel);
    end
    pulse_exit();
    repeat (G + 1) tick();
    build_frame(1, 8'hF5, 8'd3, 1'b1);
    send_q(GAP / 2);
    n_checks++;
    if (cmd_ack !== 1'b1 || motor_sel !== 2'd3) begin
      n_errors++; $display("FAIL gap_within: got ack=%b sel=%0d exp 1 3", cmd_ack, motor_sel);
    end
    pulse_exit();
    repeat (G + 1) tick();
  endtask

  task automatic test_exit_reset();
    send_byte(8'h24, 0); send_byte(8'h4D, 0); send_byte(8'h3C, 0);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_q = '{8'h01, 8'hF5, 8'h02, 8'hF6};
    send_q(0);
    n_checks++;
    if (cmd_ack !== 1'b0 || dshot_inhibit !== 1'b0) begin
      n_errors++; $display("FAIL reset_midframe: got ack=%b inh=%b exp 0 0", cmd_ack, dshot_inhibit);
    end
    build_frame(1, 8'hF5, 8'd1, 1'b1);
    send_q(0);
    repeat (3) tick();
    pulse_exit();
    n_checks++;
    if (passthrough_enable !== 1'b0 || dshot_inhibit !== 1'b1) begin
      n_errors++; $display("FAIL guard_exit: got en=%b inh=%b exp 0 1", passthrough_enable, dshot_inhibit);
    end
    repeat (G + 1) tick();
    build_frame(1, 8'hF5, 8'd3, 1'b1);
    send_q(0);
    repeat (G + 5) tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({dshot_inhibit, passthrough_enable, motor_sel, cmd_ack, cmd_nack} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_async: got %b exp 000000",
               {dshot_inhibit, passthrough_enable, motor_sel, cmd_ack, cmd_nack});
    end
    tick();
    rst = 1'b0;
    build_frame(0, 8'hF5, 8'd0, 1'b1);
    send_q(0);
    n_checks++;
    if (cmd_ack !== 1'b1 || dshot_inhibit !== 1'b1 || motor_sel !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_release: got ack=%b inh=%b sel=%0d exp 1 1 0", cmd_ack, dshot_inhibit, motor_sel);
    end
  endtask

  initial begin
    test_reset();
    test_reject();
    test_nack();
    test_entry();
    test_exit_drain();
    test_random_frames();
    test_idle_timeout();
    test_byte_gap();
    test_exit_reset();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/passthrough_entry_ctrl.md
PASSTHROUGH_ENTRY_CTRL -- requirements
Module: passthrough_entry_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 72_000_000, system clock frequency.
REQ-002 SHALL have parameter GUARD_US, default 100, delay between DShot inhibit and bridge enable.
REQ-003 SHALL have parameter IDLE_TIMEOUT_MS, default 2000, passthrough exit after no bridge activity.
REQ-004 SHALL have parameter BYTE_GAP_US, default 2000, maximum inter-byte gap within one MSP frame.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port rx_valid, input, 1, one-cycle strobe for a byte received from the USB UART.
REQ-008 SHALL have port rx_data, input, 8, received byte, valid when rx_valid=1.
REQ-009 SHALL have port bridge_active, input, 1, activity flag from the passthrough bridge.
REQ-010 SHALL have port exit_req, input, 1, one-cycle host request to leave passthrough.
REQ-011 SHALL have port dshot_inhibit, output, 1, stops DShot drive on all motor pins.
REQ-012 SHALL have port passthrough_enable, output, 1, drives the bridge enable.
REQ-013 SHALL have port motor_sel, output, 2, motor pin routed to the bridge.
REQ-014 SHALL have port cmd_ack, output, 1, one-cycle pulse: passthrough command accepted.
REQ-015 SHALL have port cmd_nack, output, 1, one-cycle pulse: valid frame with bad motor index.

Function
REQ-016 Parser FSM SHALL have states P_IDLE, P_M, P_DIR, P_LEN, P_CMD, P_PAY, P_CSUM, advancing only on rx_valid.
REQ-017 Header bytes SHALL be: P_IDLE needs 0x24 '$', P_M needs 0x4D 'M', P_DIR needs 0x3C '<'. Any other byte returns to P_IDLE; a 0x24 in P_M or P_DIR goes to P_M.
REQ-018 LEN>16 SHALL abort to P_IDLE. LEN=0 SHALL skip P_PAY.
REQ-019 Checksum SHALL be the 8-bit XOR of LEN, CMD and all payload bytes, compared against the P_CSUM byte.
REQ-020 A frame SHALL be accepted only if CMD=0xF5 and the checksum matches. Any other CMD or a checksum mismatch silently returns to P_IDLE.
REQ-021 Motor index SHALL be payload byte 0, or 0 if LEN=0. Index >3 SHALL pulse cmd_nack with no state change.
REQ-022 If the gap between bytes exceeds BYTE_GAP_US*(CLK_FREQ_HZ/1_000_000) cycles while the parser is not in P_IDLE, the parser SHALL return to P_IDLE.
REQ-023 Control FSM SHALL have states C_OFF, C_GUARD, C_ON.
REQ-024 Accepted frame in C_OFF SHALL, in the cycle after the checksum byte:
- latch motor_sel
- pulse cmd_ack
- assert dshot_inhibit
- enter C_GUARD
REQ-025 C_GUARD SHALL last exactly GUARD_US*(CLK_FREQ_HZ/1_000_000) cycles, then enter C_ON and assert passthrough_enable.
REQ-026 Accepted frame in C_GUARD or C_ON SHALL pulse cmd_ack and change nothing else; motor_sel stays fixed until C_OFF.
REQ-027 In C_ON, the idle counter SHALL clear every cycle bridge_active=1 or rx_valid=1.
- It counts IDLE_TIMEOUT_MS*(CLK_FREQ_HZ/1000) cycles, then goes to C_OFF.
- Counter width SHALL hold this value without wrap.
REQ-028 exit_req in C_GUARD or C_ON SHALL go to C_OFF next cycle. exit_req in C_OFF SHALL be ignored.
REQ-029 exit_req SHALL win over a frame accepted in the same cycle.
REQ-030 Entering C_OFF SHALL deassert passthrough_enable in the same cycle. dshot_inhibit SHALL stay high GUARD_US more, then deassert.
- C_OFF has an internal drain sub-phase for this; frames accepted during drain are ignored.
REQ-031 The parser SHALL keep running in all control states.

Reset
REQ-032 On rst, with no clock required:
- outputs: dshot_inhibit=0, passthrough_enable=0, motor_sel=0, cmd_ack=0, cmd_nack=0
- states: parser P_IDLE, control C_OFF with no drain
- all counters 0
REQ-033 rst asserted mid-frame or in C_ON SHALL abandon all progress. The first rising clk edge after release SHALL be ordinary operation.

Verification
REQ-034 Bytes 24 4D 3C 01 F5 02 F6 -> cmd_ack pulse, motor_sel=2, dshot_inhibit=1 next cycle; passthrough_enable=1 exactly 7200 cycles later.
REQ-035 Same frame with checksum F7, CMD 0x64, or LEN 0x11 -> no cmd_ack, all outputs remain 0.
REQ-036 24 4D 3C 01 F5 05 F1 -> cmd_nack pulse, dshot_inhibit stays 0.
REQ-037 Entry with IDLE_TIMEOUT_MS=1, bridge_active toggled every 50000 cycles -> stays C_ON. Activity then stops -> passthrough_enable=0 after 72000 cycles, dshot_inhibit=0 7200 cycles later.
REQ-038 Frame bytes spaced 150000 cycles apart -> no cmd_ack. A complete frame sent immediately after -> accepted.
REQ-039 exit_req in C_GUARD, then rst pulse while in C_ON -> both reach C_OFF. After rst: all outputs 0 immediately.
